// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcode constants, ALUOp codes and the control word with its per-state decode.
// Also imported by the ALU control unit, hence the generic package name.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXE  = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        ITEXE  = 4'd9,
        ITWB   = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef struct packed {
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Control word for a state; op_lsb distinguishes BNE from BEQ.
    function automatic ctrl_t ctrl_decode(input state_t st, input logic op_lsb);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_ADD;
                c.pc_write  = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                c.ior_d    = 1'b1;
                c.mem_read = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            RTEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            RTWB: begin
                c.reg_dst   = 2'b01;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = op_lsb;
            end
            ITEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALUOP_ITYPE;
            end
            ITWB: begin
                c.reg_write = 1'b1;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            JAL: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.reg_dst   = 2'b10;
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-path bundle between the multicycle FSM and the datapath.
// master (FSM side): drives datapath strobes/selects, IllegalOp and State;
//                    samples Op, Zero and MemReady.
// slave (datapath side): the mirror image.
interface multicycle_control_fsm_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;

    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic [1:0] RegDst;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, ALUSrcA,
               PCWrite, PCWriteCond, BranchNE, RegDst, ALUSrcB, ALUOp, PCSource,
               IllegalOp, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, ALUSrcA,
               PCWrite, PCWriteCond, BranchNE, RegDst, ALUSrcB, ALUOp, PCSource,
               IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control_fsm_out_decode.sv
// mips_out_decode: state -> control word lookup.
// Ports: state (FSM state), op_lsb (Op[0], selects BNE vs BEQ), ctrl (control word).
module mips_out_decode
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   op_lsb,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = ctrl_decode(state, op_lsb);
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle MIPS datapath.
// Ports: clk (rising edge), reset_n (async active-low),
//        bus (master side of multicycle_control_fsm_if: Op/Zero/MemReady in,
//        datapath controls, IllegalOp and debug State out).
// MEM_HANDSHAKE=1: FETCH/MEMRD/MEMWR wait for MemReady; 0: they take one cycle.
module multicycle_control_fsm
    import mips_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1
)
(
    input  logic                           clk,
    input  logic                           reset_n,
    multicycle_control_fsm_if.master       bus
);
    state_t state;
    state_t next_state;
    ctrl_t  ctrl_q;
    ctrl_t  next_ctrl;
    logic   illegal;
    logic   mem_go;
    logic   fetch_stall;
    logic   unused_zero;

    // Branch resolution on Zero belongs to the datapath.
    assign unused_zero = bus.Zero;

    assign mem_go = (MEM_HANDSHAKE == 0) || bus.MemReady;

    always_comb begin
        next_state = state;
        illegal    = 1'b0;
        case (state)
            FETCH:  if (mem_go) next_state = DECODE;
            DECODE: begin
                casez (bus.Op)
                    OP_LW, OP_SW:   next_state = MEMADR;
                    OP_RTYPE:       next_state = RTEXE;
                    OP_BEQ, OP_BNE: next_state = BRANCH;
                    6'b001???:      next_state = ITEXE;
                    OP_J:           next_state = JUMP;
                    OP_JAL:         next_state = JAL;
                    default: begin
                        next_state = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: next_state = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_go) next_state = MEMWB;
            MEMWR:  if (mem_go) next_state = FETCH;
            RTEXE:  next_state = RTWB;
            ITEXE:  next_state = ITWB;
            default: next_state = FETCH;
        endcase
    end

    mips_out_decode u_out_decode (
        .state  (next_state),
        .op_lsb (bus.Op[0]),
        .ctrl   (next_ctrl)
    );

    // The control word is registered alongside the state, so it is always the
    // decode of the current state (BranchNE captures Op[0] on entry to BRANCH).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FETCH;
            ctrl_q <= ctrl_decode(FETCH, 1'b0);
        end else begin
            state  <= next_state;
            ctrl_q <= next_ctrl;
        end
    end

    // While FETCH waits for memory (or is held in reset) IR and PC must not load.
    assign fetch_stall = (state == FETCH) && !(mem_go && reset_n);

    assign bus.IorD        = ctrl_q.ior_d;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.IRWrite     = ctrl_q.ir_write && !fetch_stall;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.PCWrite     = ctrl_q.pc_write && !fetch_stall;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.BranchNE    = ctrl_q.branch_ne;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.IllegalOp   = illegal;
    assign bus.State       = state;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver pushes the expected
// output vector for each cycle it drives; a monitor pops and compares on the
// falling edge. Async-reset behaviour is checked directly between edges.
module tb_multicycle_control_fsm;
    import mips_pkg::*;

    logic clk;
    logic reset_n;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_HANDSHAKE(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [22:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    logic [22:0] dut_vec;
    assign dut_vec = {bus.State, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                      bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.PCWrite,
                      bus.PCWriteCond, bus.BranchNE, bus.RegDst, bus.ALUSrcB,
                      bus.ALUOp, bus.PCSource, bus.IllegalOp};

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000101) || (op[5:3] == 3'b001) ||
               (op == 6'b000010) || (op == 6'b000011);
    endfunction

    // Expected outputs for one cycle, written from the state table.
    function automatic logic [22:0] model(input state_t st, input logic [5:0] op,
                                          input logic ready, input logic in_rst);
        logic iord, mr, mw, irw, rw, mtr, asa, pcw, pcwc, bne, ill;
        logic [1:0] rdst, asb, aop, psrc;
        {iord, mr, mw, irw, rw, mtr, asa, pcw, pcwc, bne, ill} = '0;
        {rdst, asb, aop, psrc} = '0;
        case (st)
            FETCH:  begin mr = 1; irw = ready && !in_rst; asb = 2'b01; pcw = ready && !in_rst; end
            DECODE: begin asb = 2'b11; ill = !is_legal(op); end
            MEMADR: begin asa = 1; asb = 2'b10; end
            MEMRD:  begin iord = 1; mr = 1; end
            MEMWB:  begin mtr = 1; rw = 1; end
            MEMWR:  begin iord = 1; mw = 1; end
            RTEXE:  begin asa = 1; aop = 2'b10; end
            RTWB:   begin rdst = 2'b01; rw = 1; end
            BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; bne = op[0]; end
            ITEXE:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
            ITWB:   begin rw = 1; end
            JUMP:   begin pcw = 1; psrc = 2'b10; end
            JAL:    begin pcw = 1; psrc = 2'b10; rdst = 2'b10; rw = 1; end
            default: ;
        endcase
        return {4'(st), iord, mr, mw, irw, rw, mtr, asa, pcw, pcwc, bne,
                rdst, asb, aop, psrc, ill};
    endfunction

    task automatic step(input state_t st, input logic [5:0] op, input logic ready,
                        input string name);
        sb_t e;
        bus.Op       = op;
        bus.MemReady = ready;
        bus.Zero     = ~bus.Zero;
        e.name = name;
        e.exp  = model(st, op, ready, !reset_n);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [22:0] exp);
        n_checks++;
        if (dut_vec !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, dut_vec, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (dut_vec !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, dut_vec, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        bus.Op       = OP_RTYPE;
        bus.MemReady = 1'b1;
        bus.Zero     = 1'b0;
        @(posedge clk);
        #1;
        step(FETCH, OP_RTYPE, 1'b1, "reset_ready1");
        step(FETCH, OP_RTYPE, 1'b0, "reset_ready0");
        reset_n = 1'b1;

        // LW, MemReady high: 5 cycles
        step(FETCH,  OP_LW, 1'b1, "lw_fetch");
        step(DECODE, OP_LW, 1'b1, "lw_decode");
        step(MEMADR, OP_LW, 1'b1, "lw_memadr");
        step(MEMRD,  OP_LW, 1'b1, "lw_memrd");
        step(MEMWB,  OP_LW, 1'b1, "lw_memwb");

        // SW with MemReady low 3 cycles in MEMWR; MemReady low in DECODE/MEMADR is ignored
        step(FETCH,  OP_SW, 1'b1, "sw_fetch");
        step(DECODE, OP_SW, 1'b0, "sw_decode");
        step(MEMADR, OP_SW, 1'b0, "sw_memadr");
        step(MEMWR,  OP_SW, 1'b0, "sw_memwr_wait1");
        step(MEMWR,  OP_SW, 1'b0, "sw_memwr_wait2");
        step(MEMWR,  OP_SW, 1'b0, "sw_memwr_wait3");
        step(MEMWR,  OP_SW, 1'b1, "sw_memwr_done");

        // FETCH stall, then BNE
        step(FETCH,  OP_BNE, 1'b0, "fetch_stall1");
        step(FETCH,  OP_BNE, 1'b0, "fetch_stall2");
        step(FETCH,  OP_BNE, 1'b1, "bne_fetch");
        step(DECODE, OP_BNE, 1'b1, "bne_decode");
        step(BRANCH, OP_BNE, 1'b1, "bne_branch");

        // BEQ
        step(FETCH,  OP_BEQ, 1'b1, "beq_fetch");
        step(DECODE, OP_BEQ, 1'b1, "beq_decode");
        step(BRANCH, OP_BEQ, 1'b1, "beq_branch");

        // ADDI and the top of the I-type range
        step(FETCH,  6'b001000, 1'b1, "addi_fetch");
        step(DECODE, 6'b001000, 1'b1, "addi_decode");
        step(ITEXE,  6'b001000, 1'b1, "addi_itexe");
        step(ITWB,   6'b001000, 1'b1, "addi_itwb");
        step(FETCH,  6'b001111, 1'b1, "lui_fetch");
        step(DECODE, 6'b001111, 1'b1, "lui_decode");
        step(ITEXE,  6'b001111, 1'b1, "lui_itexe");
        step(ITWB,   6'b001111, 1'b1, "lui_itwb");

        // LW with MEMRD wait
        step(FETCH,  OP_LW, 1'b1, "lw2_fetch");
        step(DECODE, OP_LW, 1'b1, "lw2_decode");
        step(MEMADR, OP_LW, 1'b0, "lw2_memadr");
        step(MEMRD,  OP_LW, 1'b0, "lw2_memrd_wait");
        step(MEMRD,  OP_LW, 1'b1, "lw2_memrd_done");
        step(MEMWB,  OP_LW, 1'b0, "lw2_memwb");

        // R-type, J, JAL
        step(FETCH,  OP_RTYPE, 1'b1, "rt_fetch");
        step(DECODE, OP_RTYPE, 1'b1, "rt_decode");
        step(RTEXE,  OP_RTYPE, 1'b1, "rt_rtexe");
        step(RTWB,   OP_RTYPE, 1'b1, "rt_rtwb");
        step(FETCH,  OP_J,     1'b1, "j_fetch");
        step(DECODE, OP_J,     1'b1, "j_decode");
        step(JUMP,   OP_J,     1'b1, "j_jump");
        step(FETCH,  OP_JAL,   1'b1, "jal_fetch");
        step(DECODE, OP_JAL,   1'b1, "jal_decode");
        step(JAL,    OP_JAL,   1'b1, "jal_jal");

        // Illegal opcodes: 2 cycles each
        step(FETCH,  6'b111111, 1'b1, "ill_fetch");
        step(DECODE, 6'b111111, 1'b1, "ill_decode");
        step(FETCH,  6'b000001, 1'b1, "ill2_fetch");
        step(DECODE, 6'b000001, 1'b1, "ill2_decode");

        // Reset pulsed mid-RTEXE between edges
        step(FETCH,  OP_RTYPE, 1'b1, "rst_rt_fetch");
        step(DECODE, OP_RTYPE, 1'b1, "rst_rt_decode");
        #1;
        check_now("rst_rtexe_before", model(RTEXE, OP_RTYPE, 1'b1, 1'b0));
        reset_n = 1'b0;
        #1;
        check_now("rst_async_fetch", model(FETCH, OP_RTYPE, 1'b1, 1'b1));
        reset_n = 1'b1;
        #1;
        step(FETCH,  OP_J, 1'b1, "post_rst_fetch");
        step(DECODE, OP_J, 1'b1, "post_rst_decode");
        step(JUMP,   OP_J, 1'b1, "post_rst_jump");
        step(FETCH,  OP_J, 1'b1, "final_fetch");

        for (int i = 0; i < 5; i++) begin
            if (sb_q.size() != 0) @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
